// File: rtl/pe_shift_iter.sv
// pe_shift_iter: iterative shift/rotate processing element.
// Accepts {ctrl, data} on a drive/free handshake. Shifts at most STEP bits
// per cycle, then holds the registered result until downstream frees it.
// Optional status flags (carry, zero, illegal mode) are enabled with the
// SHIFT_STATUS_EN macro. When the macro is undefined, the upper CW bits of
// o_data are constant zero.
module pe_shift_iter #(
  parameter int DW   = 32,
  parameter int CW   = 32,
  parameter int STEP = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_drive,
  input  logic [CW+DW-1:0]  i_data,
  output logic              o_free,
  output logic              o_drive,
  output logic [CW+DW-1:0]  o_data,
  input  logic              i_free
);

  localparam int SW = $clog2(DW);
  localparam logic [SW:0] STEP_L = (SW+1)'(STEP);
  localparam logic [SW:0] DW_L   = (SW+1)'(DW);

  localparam logic [2:0] M_LSL = 3'd0;
  localparam logic [2:0] M_LSR = 3'd1;
  localparam logic [2:0] M_ASR = 3'd2;
  localparam logic [2:0] M_ROL = 3'd3;
  localparam logic [2:0] M_ROR = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [DW-1:0]   operand;
  logic [2:0]      mode;
  logic [SW-1:0]   rem;
  logic [DW-1:0]   res_q;

  logic [2:0]      in_mode;
  logic [SW-1:0]   in_amt;
  logic [DW-1:0]   in_val;
  logic            in_legal;

  logic [SW:0]     k;
  logic [SW:0]     k_inv;
  logic [SW:0]     rem_sub;
  logic [SW-1:0]   rem_nx;
  logic [DW-1:0]   step_res;

  // Modes above ROR are illegal and produce a zero result
  function automatic logic mode_legal(input logic [2:0] m);
    return (m <= M_ROR);
  endfunction

  assign in_mode  = i_data[DW+2:DW];
  assign in_amt   = i_data[DW+3+SW-1:DW+3];
  assign in_val   = i_data[DW-1:0];
  assign in_legal = mode_legal(in_mode);

  generate
    if (CW > 3 + SW) begin : g_unused_ctrl
      logic unused_ctrl;
      assign unused_ctrl = ^{1'b0, i_data[CW+DW-1:DW+3+SW]};
    end
  endgenerate

  assign o_free  = (state == IDLE);
  assign o_drive = (state == HOLD);

  // Step size for this cycle and the shifted operand for the current mode
  always_comb begin
    k        = ({1'b0, rem} > STEP_L) ? STEP_L : {1'b0, rem};
    k_inv    = DW_L - k;
    rem_sub  = {1'b0, rem} - k;
    rem_nx   = rem_sub[SW-1:0];
    step_res = '0;
    case (mode)
      M_LSL:   step_res = operand << k;
      M_LSR:   step_res = operand >> k;
      M_ASR:   step_res = DW'($signed(operand) >>> k);
      M_ROL:   step_res = (operand << k) | (operand >> k_inv);
      M_ROR:   step_res = (operand >> k) | (operand << k_inv);
      default: step_res = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: accept in IDLE, iterate in SHIFT, release in HOLD
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (i_drive) begin
          if (!in_legal || (in_amt == '0)) begin
            state_nx = HOLD;
          end else begin
            state_nx = SHIFT;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      SHIFT: begin
        if (rem_nx == '0) begin
          state_nx = HOLD;
        end else begin
          state_nx = SHIFT;
        end
      end
      HOLD: begin
        if (i_free) begin
          state_nx = IDLE;
        end else begin
          state_nx = HOLD;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand, remaining count and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      operand <= '0;
      mode    <= 3'd0;
      rem     <= '0;
      res_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_drive) begin
            operand <= in_val;
            mode    <= in_mode;
            if (!in_legal) begin
              rem   <= '0;
              res_q <= '0;
            end else if (in_amt == '0) begin
              rem   <= '0;
              res_q <= in_val;
            end else begin
              rem   <= in_amt;
            end
          end
        end
        SHIFT: begin
          operand <= step_res;
          rem     <= rem_nx;
          if (rem_nx == '0) begin
            res_q <= step_res;
          end
        end
        default: begin
          operand <= operand;
        end
      endcase
    end
  end

`ifdef SHIFT_STATUS_EN
  logic step_carry;
  logic carry_q;
  logic zero_q;
  logic ill_q;
  logic [SW:0]   k_m1;
  logic [DW-1:0] out_hi;
  logic [DW-1:0] out_lo;

  // Last bit leaving the operand in this step
  always_comb begin
    k_m1       = k - (SW+1)'(1);
    out_hi     = operand >> k_inv;
    out_lo     = operand >> k_m1;
    step_carry = 1'b0;
    case (mode)
      M_LSL, M_ROL:        step_carry = out_hi[0];
      M_LSR, M_ASR, M_ROR: step_carry = out_lo[0];
      default:             step_carry = 1'b0;
    endcase
  end

  // Status flags, registered together with the result
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_drive && (!in_legal || (in_amt == '0))) begin
            carry_q <= 1'b0;
            ill_q   <= !in_legal;
            zero_q  <= !in_legal || (in_val == '0);
          end
        end
        SHIFT: begin
          if (rem_nx == '0) begin
            carry_q <= step_carry;
            ill_q   <= 1'b0;
            zero_q  <= (step_res == '0);
          end
        end
        default: begin
          carry_q <= carry_q;
        end
      endcase
    end
  end

  assign o_data = {{(CW-3){1'b0}}, ill_q, zero_q, carry_q, res_q};
`else
  assign o_data = {{CW{1'b0}}, res_q};
`endif

endmodule

// File: tb/tb_pe_shift_iter.sv
// Directed testbench for pe_shift_iter (DW=32, CW=32, STEP=8).
// A table of single operations is followed by sequences for backpressure
// and reset during a shift.
module tb_pe_shift_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_drive = 1'b0;
  logic [63:0] i_data = 64'd0;
  logic        o_free;
  logic        o_drive;
  logic [63:0] o_data;
  logic        i_free = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  pe_shift_iter #(.DW(32), .CW(32), .STEP(8)) dut (
    .clk(clk), .rst(rst), .i_drive(i_drive), .i_data(i_data),
    .o_free(o_free), .o_drive(o_drive), .o_data(o_data), .i_free(i_free)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  mode;
    logic [4:0]  amt;
    logic [31:0] data;
    logic [31:0] exp_res;
    int          exp_lat;
    logic        exp_carry;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] expect_word(input logic [2:0] m, input logic [31:0] r, input logic c);
    logic [63:0] v;
    v = {32'd0, r};
`ifdef SHIFT_STATUS_EN
    v[32] = c;
    v[33] = (r == 32'd0);
    v[34] = (m > 3'd4);
`endif
    return v;
  endfunction

  // Present one request while idle and return the accept-to-valid latency
  task automatic run_op(input logic [2:0] m, input logic [4:0] a, input logic [31:0] d, output int lat);
    i_data  = {24'd0, a, m, d};
    i_drive = 1'b1;
    @(posedge clk); #1;
    i_drive = 1'b0;
    lat = 1;
    while (!o_drive && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_hold();
    i_free = 1'b1;
    @(posedge clk); #1;
    i_free = 1'b0;
  endtask

  initial begin
    int lat;
    logic [63:0] held;

    vecs[0]  = '{3'd0, 5'd4,  32'h000000FF, 32'h00000FF0, 2, 1'b0};
    vecs[1]  = '{3'd2, 5'd31, 32'h80000000, 32'hFFFFFFFF, 5, 1'b0};
    vecs[2]  = '{3'd4, 5'd1,  32'h00000001, 32'h80000000, 2, 1'b1};
    vecs[3]  = '{3'd1, 5'd9,  32'h80000000, 32'h00400000, 3, 1'b0};
    vecs[4]  = '{3'd3, 5'd12, 32'h80000001, 32'h00001800, 3, 1'b0};
    vecs[5]  = '{3'd7, 5'd0,  32'h00001234, 32'h00000000, 1, 1'b0};
    vecs[6]  = '{3'd0, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 1, 1'b0};
    vecs[7]  = '{3'd0, 5'd1,  32'h80000001, 32'h00000002, 2, 1'b1};
    vecs[8]  = '{3'd2, 5'd8,  32'h40000000, 32'h00400000, 2, 1'b0};
    vecs[9]  = '{3'd4, 5'd16, 32'h12345678, 32'h56781234, 3, 1'b0};
    vecs[10] = '{3'd2, 5'd16, 32'h80000000, 32'hFFFF8000, 3, 1'b0};
    vecs[11] = '{3'd5, 5'd3,  32'h0000FFFF, 32'h00000000, 1, 1'b0};
    vecs[12] = '{3'd1, 5'd8,  32'h00000180, 32'h00000001, 2, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_free",  {63'd0, o_free},  64'd1);
    check("rst_drive", {63'd0, o_drive}, 64'd0);
    check("rst_data",  o_data,           64'd0);

    // Table-driven operations
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].mode, vecs[i].amt, vecs[i].data, lat);
      check($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("v%0d_data", i), o_data,
            expect_word(vecs[i].mode, vecs[i].exp_res, vecs[i].exp_carry));
      release_hold();
      check($sformatf("v%0d_free", i), {63'd0, o_free}, 64'd1);
    end

    // Backpressure: result held, new request ignored
    run_op(3'd0, 5'd4, 32'h000000FF, lat);
    held = o_data;
    check("bp_data0", held, expect_word(3'd0, 32'h00000FF0, 1'b0));
    i_data = {24'd0, 5'd2, 3'd1, 32'hFFFF0000};
    for (int c = 0; c < 3; c++) begin
      i_drive = (c == 1);
      @(posedge clk); #1;
      check($sformatf("bp_stable%0d", c), o_data, held);
      check($sformatf("bp_nofree%0d", c), {63'd0, o_free}, 64'd0);
      check($sformatf("bp_drive%0d", c), {63'd0, o_drive}, 64'd1);
    end
    i_drive = 1'b0;
    release_hold();
    check("bp_rel_free",  {63'd0, o_free},  64'd1);
    check("bp_rel_drive", {63'd0, o_drive}, 64'd0);
    @(posedge clk); #1;
    check("bp_no_accept", {63'd0, o_free}, 64'd1);
    check("bp_data_kept", o_data, held);

    // Reset during the second SHIFT cycle of a 31-bit shift
    i_data  = {24'd0, 5'd31, 3'd2, 32'h80000000};
    i_drive = 1'b1;
    @(posedge clk); #1;
    i_drive = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_drive", {63'd0, o_drive}, 64'd0);
    check("mid_rst_free",  {63'd0, o_free},  64'd1);
    check("mid_rst_data",  o_data,           64'd0);
    run_op(3'd0, 5'd0, 32'h00000055, lat);
    check("post_rst_lat",  64'(lat), 64'd1);
    check("post_rst_data", o_data, expect_word(3'd0, 32'h00000055, 1'b0));
    release_hold();
    check("post_rst_free", {63'd0, o_free}, 64'd1);

    // Reset while in HOLD discards the result
    run_op(3'd3, 5'd4, 32'hF0000000, lat);
    check("hold_rst_pre", o_data, expect_word(3'd3, 32'h0000000F, 1'b1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("hold_rst_drive", {63'd0, o_drive}, 64'd0);
    check("hold_rst_data",  o_data,           64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
